// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INST_WORD_BYTES    = 32'd4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        trap;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order queue of fetched entries; a flush empties it and may load one entry at the same edge.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop_ok;
    fetch_entry_t     mem [DEPTH];

    assign pop_ok = pop && (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= PTR_W'(push);
            count  <= CNT_W'(push);
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop_ok);
        end
    end

    // Storage is not reset; entries are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push)
            mem[flush ? '0 : wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC generation, credit-limited request issue, stale-response dropping and redirect handling.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT,
    parameter int          DEPTH      = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_trap
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    logic [31:0]      fetch_pc;
    logic [31:0]      rsp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop;
    logic [CNT_W-1:0] occupancy;
    logic             halted;

    logic             rsp_take;
    logic             req_fire;
    logic             misaligned;
    logic [SUM_W-1:0] credit_sum;
    logic             q_push;
    logic             q_pop;
    fetch_entry_t     q_entry;
    fetch_entry_t     head;

    // A response with nothing outstanding is a leftover from before reset.
    assign rsp_take   = i_imem_rsp_valid && (outstanding != '0);
    assign misaligned = (i_redirect_pc[1:0] != 2'b00);
    assign credit_sum = SUM_W'(occupancy) + SUM_W'(outstanding) - SUM_W'(drop);

    assign o_imem_req_valid = !i_rst && !halted && !i_redirect_valid &&
                              (credit_sum < SUM_W'(DEPTH));
    assign o_imem_req_addr  = fetch_pc;
    assign req_fire         = o_imem_req_valid && i_imem_req_ready;

    assign o_inst_valid = (occupancy != '0);
    assign o_inst       = o_inst_valid ? head.inst : 32'd0;
    assign o_inst_pc    = o_inst_valid ? head.pc   : 32'd0;
    assign o_inst_trap  = o_inst_valid ? head.trap : 1'b0;
    assign q_pop        = o_inst_valid && i_inst_ready;

    always_comb begin
        q_push  = 1'b0;
        q_entry = '{inst: i_imem_rsp_data, pc: rsp_pc, trap: 1'b0};
        if (i_redirect_valid) begin
            q_push  = misaligned;
            q_entry = '{inst: 32'd0, pc: i_redirect_pc, trap: 1'b1};
        end else begin
            q_push  = rsp_take && (drop == '0);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fetch_pc    <= RESET_ADDR;
            rsp_pc      <= RESET_ADDR;
            outstanding <= '0;
            drop        <= '0;
            halted      <= 1'b0;
        end else begin
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_take);
            if (i_redirect_valid) begin
                // Everything still in flight belongs to the abandoned path.
                drop     <= outstanding - CNT_W'(rsp_take);
                fetch_pc <= i_redirect_pc;
                rsp_pc   <= i_redirect_pc;
                halted   <= misaligned;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + INST_WORD_BYTES;
                if (rsp_take) begin
                    if (drop != '0)
                        drop <= drop - CNT_W'(1);
                    else
                        rsp_pc <= rsp_pc + INST_WORD_BYTES;
                end
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .clk        (i_clk),
        .rst        (i_rst),
        .flush      (i_redirect_valid),
        .push       (q_push),
        .push_entry (q_entry),
        .pop        (q_pop),
        .head       (head),
        .count      (occupancy)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit against an architectural fetch-stream model.
module tb_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RST_A = 32'h0000_0000;

    logic        i_clk;
    logic        i_rst;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        o_inst_trap;

    fetch_unit #(.RESET_ADDR(RST_A), .DEPTH(DEPTH)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_req_addr  (o_imem_req_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_inst_valid     (o_inst_valid),
        .i_inst_ready     (i_inst_ready),
        .o_inst           (o_inst),
        .o_inst_pc        (o_inst_pc),
        .o_inst_trap      (o_inst_trap)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       memq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc, lat, stale;
    int          n_fire, n_deliv, n_trap, first_cyc;
    bit          first_seen;
    logic [31:0] first_pc;
    logic [31:0] exp_pc, exp_req;
    bit          trap_pend, halted_m;
    bit          rreq, rinst, red_v, force_stray;
    logic [31:0] red_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        memq.delete();
        stale     = 0;
        exp_pc    = RST_A;
        exp_req   = RST_A;
        trap_pend = 0;
        halted_m  = 0;
        cyc       = 0;
    endtask

    task automatic do_reset();
        i_rst            = 1'b1;
        i_imem_rsp_valid = 1'b0;
        i_redirect_valid = 1'b0;
        red_v            = 0;
        force_stray      = 0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        reset_model();
    endtask

    task automatic clear_stats();
        n_fire = 0; n_deliv = 0; n_trap = 0; first_seen = 0; first_cyc = -1; first_pc = 32'd0;
    endtask

    // One clock cycle: drive at the falling edge, check, then commit the model at the rising edge.
    task automatic tick();
        bit rsp_now, fire, deliver;
        int live;
        i_imem_req_ready = rreq;
        i_inst_ready     = rinst;
        i_redirect_valid = red_v;
        i_redirect_pc    = red_pc;
        rsp_now          = 0;
        if (force_stray) begin
            i_imem_rsp_valid = 1'b1;
            i_imem_rsp_data  = 32'hDEAD_BEEF;
        end else if (memq.size() > 0 && memq[0].due <= cyc) begin
            rsp_now          = 1;
            i_imem_rsp_valid = 1'b1;
            i_imem_rsp_data  = mem_word(memq[0].addr);
        end else begin
            i_imem_rsp_valid = 1'b0;
            i_imem_rsp_data  = $urandom;
        end
        #1;
        if (halted_m || red_v)
            check("no_req_when_halted_or_redirect", {31'd0, o_imem_req_valid}, 32'd0);
        if (o_imem_req_valid)
            check("req_addr", o_imem_req_addr, exp_req);
        live = memq.size() - stale;
        check("inflight_bound", {31'd0, (live <= DEPTH)}, 32'd1);
        fire    = o_imem_req_valid && i_imem_req_ready;
        deliver = o_inst_valid && i_inst_ready && !red_v;
        if (deliver) begin
            if (!first_seen) begin
                first_seen = 1; first_pc = o_inst_pc; first_cyc = cyc;
            end
            if (trap_pend) begin
                check("trap_pc", o_inst_pc, exp_pc);
                check("trap_flag", {31'd0, o_inst_trap}, 32'd1);
                check("trap_inst", o_inst, 32'd0);
                trap_pend = 0;
                n_trap++;
            end else if (halted_m) begin
                check("delivery_while_halted", {31'd0, o_inst_valid}, 32'd0);
            end else begin
                check("inst_pc", o_inst_pc, exp_pc);
                check("inst_word", o_inst, mem_word(exp_pc));
                check("inst_trap", {31'd0, o_inst_trap}, 32'd0);
                exp_pc = exp_pc + 32'd4;
            end
            n_deliv++;
        end
        if (fire) n_fire++;
        @(posedge i_clk);
        if (rsp_now) begin
            void'(memq.pop_front());
            if (stale > 0) stale--;
        end
        if (red_v) begin
            stale     = memq.size();
            exp_req   = red_pc;
            exp_pc    = red_pc;
            trap_pend = (red_pc[1:0] != 2'b00);
            halted_m  = trap_pend;
        end
        if (fire) begin
            memq.push_back('{addr: o_imem_req_addr, due: cyc + lat});
            exp_req = exp_req + 32'd4;
        end
        cyc++;
        @(negedge i_clk);
        red_v       = 0;
        force_stray = 0;
    endtask

    initial begin
        logic [31:0] r;
        i_rst = 1'b0; i_imem_req_ready = 1'b0; i_inst_ready = 1'b0;
        i_imem_rsp_valid = 1'b0; i_imem_rsp_data = 32'd0;
        i_redirect_valid = 1'b0; i_redirect_pc = 32'd0;
        red_v = 0; red_pc = 32'd0; force_stray = 0; lat = 1; rreq = 1; rinst = 1;
        #2;
        i_rst = 1'b1;
        @(negedge i_clk);
        check("rst_req_valid", {31'd0, o_imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'd0, o_inst_valid}, 32'd0);
        check("rst_inst", o_inst, 32'd0);
        check("rst_inst_pc", o_inst_pc, 32'd0);
        check("rst_inst_trap", {31'd0, o_inst_trap}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        reset_model();

        // Streaming with single-cycle memory
        clear_stats();
        for (int i = 0; i < 18; i++) tick();
        check("fill_latency", 32'(first_cyc), 32'd2);
        check("stream_count", 32'(n_deliv), 32'd16);

        // Decode stall: credit limits requests, then drain in order
        do_reset();
        clear_stats();
        rinst = 0;
        for (int i = 0; i < 10; i++) tick();
        check("stall_req_count", 32'(n_fire), 32'(DEPTH));
        check("stall_req_valid", {31'd0, o_imem_req_valid}, 32'd0);
        clear_stats();
        rinst = 1;
        for (int i = 0; i < 8; i++) tick();
        check("drain_first_pc", first_pc, 32'd0);
        check("drain_count_ok", {31'd0, (n_deliv >= DEPTH)}, 32'd1);
        rinst = 0;
        for (int i = 0; i < 10; i++) tick();
        check("refill_valid", {31'd0, o_inst_valid}, 32'd1);

        // Asynchronous reset with a full queue
        i_rst = 1'b1;
        #1;
        check("midrst_req_valid", {31'd0, o_imem_req_valid}, 32'd0);
        check("midrst_inst_valid", {31'd0, o_inst_valid}, 32'd0);
        check("midrst_inst", o_inst, 32'd0);
        check("midrst_inst_pc", o_inst_pc, 32'd0);
        check("midrst_inst_trap", {31'd0, o_inst_trap}, 32'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        reset_model();
        clear_stats();
        rinst = 1;
        force_stray = 1;
        tick();
        check("stray_rsp_ignored", {31'd0, o_inst_valid}, 32'd0);
        for (int i = 0; i < 10; i++) tick();
        check("post_reset_first_pc", first_pc, RST_A);
        check("post_reset_count", 32'(n_deliv), 32'd9);

        // Redirect with two requests in flight to a 3-cycle memory
        do_reset();
        lat = 3;
        tick(); tick();
        check("inflight_before_redirect", 32'(memq.size()), 32'd2);
        clear_stats();
        red_v = 1; red_pc = 32'h0000_0100;
        tick();
        for (int i = 0; i < 8; i++) tick();
        check("redir_first_pc", first_pc, 32'h0000_0100);
        check("redir_count_ok", {31'd0, (n_deliv >= 2)}, 32'd1);

        // Redirect in the same cycle as a response
        do_reset();
        lat = 1;
        tick(); tick();
        check("rsp_pending_at_redirect", {31'd0, (memq.size() > 0 && memq[0].due <= cyc)}, 32'd1);
        clear_stats();
        red_v = 1; red_pc = 32'h0000_0300;
        tick();
        check("flush_empty", {31'd0, o_inst_valid}, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        check("redir2_first_pc", first_pc, 32'h0000_0300);

        // Misaligned redirect traps and halts fetch
        red_v = 1; red_pc = 32'h0000_0102;
        tick();
        check("trap_head_valid", {31'd0, o_inst_valid}, 32'd1);
        check("trap_head_flag", {31'd0, o_inst_trap}, 32'd1);
        check("trap_head_pc", o_inst_pc, 32'h0000_0102);
        check("trap_head_inst", o_inst, 32'd0);
        clear_stats();
        for (int i = 0; i < 10; i++) tick();
        check("halt_no_requests", 32'(n_fire), 32'd0);
        check("trap_once", 32'(n_trap), 32'd1);
        clear_stats();
        red_v = 1; red_pc = 32'h0000_0200;
        tick();
        for (int i = 0; i < 8; i++) tick();
        check("resume_first_pc", first_pc, 32'h0000_0200);

        // PC wraps past the top of the address space
        clear_stats();
        red_v = 1; red_pc = 32'hFFFF_FFF8;
        tick();
        for (int i = 0; i < 10; i++) tick();
        check("wrap_first_pc", first_pc, 32'hFFFF_FFF8);
        check("wrap_count_ok", {31'd0, (n_deliv >= 4)}, 32'd1);

        // Randomized traffic, redirects and latencies
        clear_stats();
        for (int i = 0; i < 900; i++) begin
            if (i % 150 == 0) lat = $urandom_range(1, 3);
            rreq  = ($urandom_range(0, 3) != 0);
            rinst = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 39) == 0 || (halted_m && $urandom_range(0, 7) == 0)) begin
                r = $urandom;
                red_v  = 1;
                red_pc = ($urandom_range(0, 5) == 0) ? (r | 32'd1) : (r & 32'hFFFF_FFFC);
            end
            tick();
        end
        check("random_progress", {31'd0, (n_deliv >= 100)}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
